// File: rtl/superfrog_video_pkg.sv
// superfrog_video_pkg: shared 640x480 timing constants and sprite FSM state type
package superfrog_video_pkg;
  localparam int CORDW = 16;
  localparam int H_RES = 640;
  localparam int V_RES = 480;
  localparam int H_STA = -160;
  localparam int V_STA = -45;
  localparam int SPR_LAT = 2;
  typedef enum logic [1:0] {IDLE, REG_POS, WAIT_POS, DRAW} spr_state_t;
endpackage

// File: rtl/sprite_renderer.sv
// sprite_renderer: walks one scaled sprite bitmap from an external sync ROM, two-cycle pixel latency
module sprite_renderer #(
  parameter int CORDW = superfrog_video_pkg::CORDW,
  parameter int H_RES = superfrog_video_pkg::H_RES,
  parameter int SPR_W = 16,
  parameter int SPR_H = 16,
  parameter int SCALE_SHIFT = 1,
  parameter int COLRW = 4,
  parameter logic [COLRW-1:0] TRANS_IDX = '0,
  localparam int ADDRW = $clog2(SPR_W*SPR_H)
) (
  input  logic                    clk_pix,
  input  logic                    rst_pix,
  input  logic                    line,
  input  logic signed [CORDW-1:0] sx,
  input  logic signed [CORDW-1:0] sy,
  input  logic signed [CORDW-1:0] sprx,
  input  logic signed [CORDW-1:0] spry,
  output logic [ADDRW-1:0]        rom_addr,
  input  logic [COLRW-1:0]        rom_data,
  output logic [COLRW-1:0]        pix,
  output logic                    drawing
);
  import superfrog_video_pkg::*;
  localparam int COLW = $clog2(SPR_W);
  localparam int RW = ADDRW - COLW;
  localparam int SCW = SCALE_SHIFT > 0 ? SCALE_SHIFT : 1;
  localparam logic [SCW-1:0] SC_MAX = SCW'((1 << SCALE_SHIFT) - 1);
  localparam logic [COLW-1:0] COL_MAX = COLW'(SPR_W - 1);
  localparam logic signed [CORDW:0] SPAN = (CORDW+1)'(SPR_H << SCALE_SHIFT);
  localparam logic signed [CORDW-1:0] X_MAX = CORDW'(H_RES);
  spr_state_t state, state_n;
  logic signed [CORDW-1:0] sprx_l, spry_l;
  logic signed [CORDW:0] dy;
  logic [SCW-1:0] scnt;
  logic [COLW-1:0] col;
  logic [ADDRW-1:0] row_base;
  logic in_rows, match, wrap, last, draw_en, draw_en_d1;
  // one extra bit keeps the vertical difference free of overflow
  assign dy = {sy[CORDW-1], sy} - {spry_l[CORDW-1], spry_l};
  assign in_rows = !dy[CORDW] && dy < SPAN;
  assign row_base = {dy[SCALE_SHIFT +: RW], COLW'(0)};
  assign match = sx == sprx_l && sprx_l < X_MAX;
  assign wrap = scnt == SC_MAX;
  assign last = wrap && col == COL_MAX;
  always_comb begin
    state_n = state;
    draw_en = 1'b0;
    if (line) state_n = REG_POS;
    else case (state)
      REG_POS:  state_n = in_rows ? WAIT_POS : IDLE;
      WAIT_POS: begin
        draw_en = match;
        state_n = match ? (last ? IDLE : DRAW) : WAIT_POS;
      end
      DRAW: begin
        draw_en = 1'b1;
        state_n = last ? IDLE : DRAW;
      end
      default: state_n = state;
    endcase
  end
  always_ff @(posedge clk_pix or posedge rst_pix) begin
    if (rst_pix) begin
      state <= IDLE;
      rom_addr <= '0;
      sprx_l <= '0;
      spry_l <= '0;
      scnt <= '0;
      col <= '0;
      draw_en_d1 <= 1'b0;
      pix <= '0;
      drawing <= 1'b0;
    end else begin
      state <= state_n;
      draw_en_d1 <= draw_en;
      pix <= rom_data;
      drawing <= draw_en_d1 && rom_data != TRANS_IDX;
      if (line) begin
        sprx_l <= sprx;
        spry_l <= spry;
        scnt <= '0;
        col <= '0;
      end else if (state == REG_POS && in_rows) rom_addr <= row_base;
      else if (draw_en) begin
        scnt <= wrap ? '0 : scnt + 1'b1;
        col <= wrap ? col + 1'b1 : col;
        rom_addr <= wrap ? rom_addr + 1'b1 : rom_addr;
      end
    end
  end
endmodule
